// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter and its latency counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LAM  = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MEM_LAT_DEFAULT = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Fixed-latency access counter: loads 1 on grant, counts while busy, flags MEM_LAT.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic clk,
    input  logic reset_in,
    input  logic i_load,
    input  logic i_en,
    input  logic i_clr,
    output logic o_done
);

    localparam int CW = $clog2(MEM_LAT + 1);

    logic [CW-1:0] r_cnt;

    // Holds at MEM_LAT once reached, so it can never wrap before the clear.
    always_ff @(posedge clk) begin
        if (reset_in || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(1);
        end else if (i_en && !o_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = (r_cnt == CW'(MEM_LAT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (IF) and load/store (LAM) with fixed latency.
// Define ARB_RR_EN for round-robin on simultaneous requests; default is LAM-first priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset_in,
    input  logic          req_if,
    input  logic [AW-1:0] addr_if,
    input  logic          req_lam,
    input  logic          rw_lam,
    input  logic [AW-1:0] addr_lam,
    input  logic [DW-1:0] wdata_lam,
    output logic          gnt_if,
    output logic          gnt_lam,
    output logic          ready_if,
    output logic          ready_lam,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        r_state;
    state_t        w_state_nxt;
    owner_t        r_owner;
    owner_t        w_pick;
    logic          w_load;
    logic          w_finish;
    logic          w_clr;
    logic          w_cnt_done;
    logic          r_gnt_if;
    logic          r_gnt_lam;
    logic          r_ready_if;
    logic          r_ready_lam;
    logic [DW-1:0] r_rdata;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

`ifdef ARB_RR_EN
    owner_t r_last_owner;

    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_last_owner <= OWN_IF;
        end else if (w_load) begin
            r_last_owner <= w_pick;
        end
    end
`endif

    mem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat (
        .clk      (clk),
        .reset_in (reset_in),
        .i_load   (w_load),
        .i_en     (r_state == BUSY),
        .i_clr    (w_clr),
        .o_done   (w_cnt_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pick      = OWN_NONE;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_if || req_lam) begin
`ifdef ARB_RR_EN
                    if (req_if && req_lam) begin
                        w_pick = (r_last_owner == OWN_LAM) ? OWN_IF : OWN_LAM;
                    end else begin
                        w_pick = req_lam ? OWN_LAM : OWN_IF;
                    end
`else
                    w_pick = req_lam ? OWN_LAM : OWN_IF;
`endif
                    w_load      = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_cnt_done) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_clr       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_clr       = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready and rdata live only for the DONE cycle; address/data are frozen for all of BUSY.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_owner     <= OWN_NONE;
            r_gnt_if    <= 1'b0;
            r_gnt_lam   <= 1'b0;
            r_ready_if  <= 1'b0;
            r_ready_lam <= 1'b0;
            r_rdata     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_ready_if  <= 1'b0;
            r_ready_lam <= 1'b0;
            r_rdata     <= '0;
            if (w_load) begin
                r_owner     <= w_pick;
                r_gnt_if    <= (w_pick == OWN_IF);
                r_gnt_lam   <= (w_pick == OWN_LAM);
                r_mem_en    <= 1'b1;
                r_mem_we    <= (w_pick == OWN_LAM) && rw_lam;
                r_mem_addr  <= (w_pick == OWN_LAM) ? addr_lam : addr_if;
                r_mem_wdata <= ((w_pick == OWN_LAM) && rw_lam) ? wdata_lam : '0;
            end else if (w_finish) begin
                r_gnt_if    <= 1'b0;
                r_gnt_lam   <= 1'b0;
                r_mem_en    <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= '0;
                r_mem_wdata <= '0;
                r_rdata     <= mem_rdata;
                r_ready_if  <= (r_owner == OWN_IF);
                r_ready_lam <= (r_owner == OWN_LAM);
            end else if (w_clr) begin
                r_owner <= OWN_NONE;
            end
        end
    end

    assign gnt_if    = r_gnt_if;
    assign gnt_lam   = r_gnt_lam;
    assign ready_if  = r_ready_if;
    assign ready_lam = r_ready_lam;
    assign rdata     = r_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard and multi-cycle corner sequences.
module tb_mem_port_arbiter;

    localparam int LAT0 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_if, req_lam, rw_lam;
    logic [31:0] addr_if, addr_lam, wdata_lam;
    logic        gnt_if, gnt_lam, ready_if, ready_lam, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic        req_if1, req_lam1, rw_lam1;
    logic [31:0] addr_if1, addr_lam1, wdata_lam1;
    logic        gnt_if1, gnt_lam1, ready_if1, ready_lam1, mem_en1, mem_we1;
    logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    // Memory model: data depends on the address; a poison value when the port is idle.
    assign mem_rdata  = mem_en  ? {mem_addr[15:0], 16'hC0DE}  : 32'hBAD0_0BAD;
    assign mem_rdata1 = mem_en1 ? {mem_addr1[15:0], 16'hC0DE} : 32'hBAD0_0BAD;

    mem_port_arbiter #(.MEM_LAT(LAT0), .AW(32), .DW(32)) u0 (
        .clk(clk), .reset_in(rst),
        .req_if(req_if), .addr_if(addr_if),
        .req_lam(req_lam), .rw_lam(rw_lam), .addr_lam(addr_lam), .wdata_lam(wdata_lam),
        .gnt_if(gnt_if), .gnt_lam(gnt_lam), .ready_if(ready_if), .ready_lam(ready_lam),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) u1 (
        .clk(clk), .reset_in(rst),
        .req_if(req_if1), .addr_if(addr_if1),
        .req_lam(req_lam1), .rw_lam(rw_lam1), .addr_lam(addr_lam1), .wdata_lam(wdata_lam1),
        .gnt_if(gnt_if1), .gnt_lam(gnt_lam1), .ready_if(ready_if1), .ready_lam(ready_lam1),
        .rdata(rdata1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    typedef struct {
        logic        is_lam;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        lam;
        logic [31:0] rdata;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, {gnt_if, gnt_lam, ready_if, ready_lam, mem_en, mem_we}, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    task automatic wait_ready(input int bound, output int n);
        n = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (ready_if || ready_lam) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_ready: no ready within %0d cycles", bound);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_if = 1'b0; req_lam = 1'b0; req_if1 = 1'b0; req_lam1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        if (v.is_lam) begin
            req_lam = 1'b1; rw_lam = v.rw; addr_lam = v.addr; wdata_lam = v.wdata;
            addr_if = 32'h5555_0000;
        end else begin
            req_if = 1'b1; addr_if = v.addr;
            rw_lam = 1'b1; addr_lam = 32'hAAAA_0000; wdata_lam = 32'h1111_2222;
        end
        sb_q.push_back('{v.is_lam, v.exp_rdata});
        for (int k = 1; k <= LAT0; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d_gnt_c%0d", idx, k), {gnt_lam, gnt_if}, v.is_lam ? 2'b10 : 2'b01);
            chk($sformatf("v%0d_en_c%0d", idx, k), mem_en, 1);
            chk($sformatf("v%0d_we_c%0d", idx, k), mem_we, v.exp_we);
            chk($sformatf("v%0d_addr_c%0d", idx, k), mem_addr, v.addr);
            chk($sformatf("v%0d_wdata_c%0d", idx, k), mem_wdata, v.exp_wdata);
            chk($sformatf("v%0d_rdy_c%0d", idx, k), {ready_lam, ready_if}, 0);
        end
        @(negedge clk);
        chk($sformatf("v%0d_rdy", idx), {ready_lam, ready_if}, v.is_lam ? 2'b10 : 2'b01);
        chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
        chk($sformatf("v%0d_done_gnt", idx), {gnt_lam, gnt_if, mem_en}, 0);
        req_if = 1'b0; req_lam = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_after", idx), {ready_lam, ready_if}, 0);
        chk($sformatf("v%0d_after_rdata", idx), rdata, 0);
    endtask

    // Scoreboard and mutual-exclusion monitor for the MEM_LAT=4 instance.
    always @(negedge clk) begin
        sb_t e;
        if (!rst) begin
            if (gnt_if && gnt_lam) begin
                n_tests++; n_fail++;
                $display("FAIL gnt_excl: gnt_if=%b gnt_lam=%b", gnt_if, gnt_lam);
            end
            if (ready_if || ready_lam) begin
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_unexpected: ready_if=%b ready_lam=%b with nothing expected",
                             ready_if, ready_lam);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_owner", {ready_lam, ready_if}, e.lam ? 2'b10 : 2'b01);
                    chk("sb_rdata", rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        logic own_seq[4];
        int   n;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0, 32'h0040_C0DE};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 32'h0100_C0DE};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2468, 32'h1234_5678, 1'b0, 32'h0, 32'h2468_C0DE};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 32'hFFFC_C0DE};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'h0000_C0DE};
`ifdef ARB_RR_EN
        own_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        own_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        rst = 1'b1;
        req_if = 1'b0; req_lam = 1'b0; rw_lam = 1'b0;
        addr_if = '0; addr_lam = '0; wdata_lam = '0;
        req_if1 = 1'b0; req_lam1 = 1'b0; rw_lam1 = 1'b0;
        addr_if1 = '0; addr_lam1 = '0; wdata_lam1 = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Simultaneous requests: LAM first, IF in the IDLE cycle after LAM's DONE.
        do_reset();
        req_if = 1'b1; addr_if = 32'h44;
        req_lam = 1'b1; rw_lam = 1'b0; addr_lam = 32'h108;
        sb_q.push_back('{1'b1, 32'h0108_C0DE});
        sb_q.push_back('{1'b0, 32'h0044_C0DE});
        @(negedge clk);
        chk("both_first_gnt", {gnt_lam, gnt_if}, 2'b10);
        wait_ready(20, n);
        chk("both_lam_lat", n, LAT0);
        chk("both_lam_rdy", {ready_lam, ready_if}, 2'b10);
        req_lam = 1'b0;
        @(negedge clk);
        chk("both_idle_gap", {gnt_lam, gnt_if}, 0);
        @(negedge clk);
        chk("both_if_gnt", {gnt_lam, gnt_if}, 2'b01);
        wait_ready(20, n);
        chk("both_if_lat", n, LAT0);
        req_if = 1'b0;
        @(negedge clk);

        // Both held continuously for four accesses.
        do_reset();
        req_if = 1'b1; addr_if = 32'h80;
        req_lam = 1'b1; rw_lam = 1'b0; addr_lam = 32'h200;
        for (int i = 0; i < 4; i++)
            sb_q.push_back('{own_seq[i], own_seq[i] ? 32'h0200_C0DE : 32'h0080_C0DE});
        for (int i = 0; i < 4; i++) begin
            wait_ready(30, n);
            chk($sformatf("held_period_%0d", i), n, (i == 0) ? LAT0 + 1 : LAT0 + 2);
        end
        req_if = 1'b0; req_lam = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_quiet", {gnt_lam, gnt_if, mem_en}, 0);

        // Reset while BUSY at cnt==2 aborts; a fresh request is then served normally.
        req_if = 1'b1; addr_if = 32'h40;
        @(negedge clk);
        chk("abort_gnt_c1", gnt_if, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("abort");
        rst = 1'b0;
        sb_q.push_back('{1'b0, 32'h0040_C0DE});
        wait_ready(20, n);
        chk("abort_regrant_lat", n, LAT0 + 1);
        req_if = 1'b0;
        @(negedge clk);
        chk_idle("abort_end");

        // MEM_LAT=1 instance: store with the request dropped mid-BUSY, then a fetch.
        req_lam1 = 1'b1; rw_lam1 = 1'b1; addr_lam1 = 32'h300; wdata_lam1 = 32'hCAFE_F00D;
        @(negedge clk);
        chk("l1_gnt", {gnt_lam1, gnt_if1, mem_en1}, 3'b101);
        chk("l1_we", mem_we1, 1);
        chk("l1_addr", mem_addr1, 32'h300);
        chk("l1_wdata", mem_wdata1, 32'hCAFE_F00D);
        chk("l1_no_rdy", {ready_lam1, ready_if1}, 0);
        req_lam1 = 1'b0;
        @(negedge clk);
        chk("l1_rdy", {ready_lam1, ready_if1}, 2'b10);
        chk("l1_rdata", rdata1, 32'h0300_C0DE);
        chk("l1_done_gnt", {gnt_lam1, gnt_if1, mem_en1, mem_we1}, 0);
        @(negedge clk);
        chk("l1_after", {ready_lam1, ready_if1}, 0);
        req_if1 = 1'b1; addr_if1 = 32'h10;
        @(negedge clk);
        chk("l1_if_gnt", {gnt_lam1, gnt_if1}, 2'b01);
        chk("l1_if_wdata", mem_wdata1, 0);
        @(negedge clk);
        chk("l1_if_rdy", {ready_lam1, ready_if1}, 2'b01);
        chk("l1_if_rdata", rdata1, 32'h0010_C0DE);
        req_if1 = 1'b0;
        @(negedge clk);
        chk("l1_if_after", rdata1, 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
